// File: rtl/axi_lite_cfg_master_if.sv
// AXI4-Lite bus bundle between the config master and the register block slave.
interface axi_lite_cfg_master_if #(
  parameter int DW = 32,
  parameter int AW = 16
);
  logic [AW-1:0]   M_AXI_AWADDR;
  logic            M_AXI_AWVALID;
  logic            M_AXI_AWREADY;
  logic [DW-1:0]   M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WVALID;
  logic            M_AXI_WREADY;
  logic [1:0]      M_AXI_BRESP;
  logic            M_AXI_BVALID;
  logic            M_AXI_BREADY;
  logic [AW-1:0]   M_AXI_ARADDR;
  logic            M_AXI_ARVALID;
  logic            M_AXI_ARREADY;
  logic [DW-1:0]   M_AXI_RDATA;
  logic [1:0]      M_AXI_RRESP;
  logic            M_AXI_RVALID;
  logic            M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/axi_lite_cfg_master.sv
// Single-outstanding AXI4-Lite initiator: cmd/rsp handshakes in, AXI4-Lite transactions out.
// Optional response-wait timeout with sticky error when AXI_MASTER_TIMEOUT_EN is defined.
module axi_lite_cfg_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_data,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_strb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]                      rsp_resp,
  output logic                            busy,
`ifdef AXI_MASTER_TIMEOUT_EN
  output logic                            timeout_err,
`endif
  axi_lite_cfg_master_if.master           m_axi
);
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;

  if (!(DW == 32 || DW == 64)) begin : g_bad_dw
    $error("axi_lite_cfg_master: C_M_AXI_DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("axi_lite_cfg_master: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RESP} state_t;

  state_t          r_state, w_next;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wstrb;
  logic            r_write;
  logic            r_awvalid, r_wvalid;
  logic            r_aw_done, r_w_done;
  logic [DW-1:0]   r_rsp_data;
  logic [1:0]      r_rsp_resp;
  logic            w_cmd_ready, w_bready, w_rready, w_arvalid, w_rsp_valid;
  logic            w_aw_hs, w_w_hs, w_to, w_block;

  assign w_aw_hs = r_awvalid & m_axi.M_AXI_AWREADY;
  assign w_w_hs  = r_wvalid  & m_axi.M_AXI_WREADY;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int            CW     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] r_to_cnt;
  logic          r_timeout_err;

  assign w_to        = (r_to_cnt == TO_LIM);
  assign w_block     = r_timeout_err;
  assign timeout_err = r_timeout_err;

  // Counter restarts on every state change, so each wait phase is timed on its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != w_next || !(r_state == WR_B || r_state == RD_R))
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;
      if ((r_state == WR_B && w_to && !m_axi.M_AXI_BVALID) ||
          (r_state == RD_R && w_to && !m_axi.M_AXI_RVALID))
        r_timeout_err <= 1'b1;
    end
  end
`else
  assign w_to    = 1'b0;
  assign w_block = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_bready    = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmd_ready = !w_block;
        if (cmd_valid && !w_block) w_next = cmd_write ? WR : RD_A;
      end
      WR: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = WR_B;
      end
      WR_B: begin
        // A late BVALID on the timeout cycle is still honoured.
        w_bready = !w_to || m_axi.M_AXI_BVALID;
        if (m_axi.M_AXI_BVALID || w_to) w_next = RESP;
      end
      RD_A: begin
        w_arvalid = 1'b1;
        if (m_axi.M_AXI_ARREADY) w_next = RD_R;
      end
      RD_R: begin
        w_rready = !w_to || m_axi.M_AXI_RVALID;
        if (m_axi.M_AXI_RVALID || w_to) w_next = RESP;
      end
      RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_write    <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_resp <= 2'b00;
    end else begin
      case (r_state)
        IDLE: if (cmd_valid && w_cmd_ready) begin
          r_addr    <= cmd_addr;
          r_wdata   <= cmd_data;
          r_wstrb   <= cmd_strb;
          r_write   <= cmd_write;
          r_awvalid <= cmd_write;
          r_wvalid  <= cmd_write;
        end
        WR: begin
          if (w_aw_hs) begin r_awvalid <= 1'b0; r_aw_done <= 1'b1; end
          if (w_w_hs)  begin r_wvalid  <= 1'b0; r_w_done  <= 1'b1; end
          if (w_next == WR_B) begin r_aw_done <= 1'b0; r_w_done <= 1'b0; end
        end
        WR_B: begin
          if (m_axi.M_AXI_BVALID) begin
            r_rsp_resp <= m_axi.M_AXI_BRESP;
            r_rsp_data <= '0;
          end else if (w_to) begin
            r_rsp_resp <= 2'b11;
            r_rsp_data <= '0;
          end
        end
        RD_R: begin
          if (m_axi.M_AXI_RVALID) begin
            r_rsp_resp <= m_axi.M_AXI_RRESP;
            r_rsp_data <= m_axi.M_AXI_RDATA;
          end else if (w_to) begin
            r_rsp_resp <= 2'b11;
            r_rsp_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = w_rsp_valid;
  assign rsp_write = r_write;
  assign rsp_data  = r_rsp_data;
  assign rsp_resp  = r_rsp_resp;
  assign busy      = (r_state != IDLE);

  assign m_axi.M_AXI_AWADDR  = r_addr;
  assign m_axi.M_AXI_AWVALID = r_awvalid;
  assign m_axi.M_AXI_WDATA   = r_wdata;
  assign m_axi.M_AXI_WSTRB   = r_wstrb;
  assign m_axi.M_AXI_WVALID  = r_wvalid;
  assign m_axi.M_AXI_BREADY  = w_bready;
  assign m_axi.M_AXI_ARADDR  = r_addr;
  assign m_axi.M_AXI_ARVALID = w_arvalid;
  assign m_axi.M_AXI_RREADY  = w_rready;
endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// Directed bench for axi_lite_cfg_master: delay-programmable AXI-Lite slave plus response scoreboard.
module tb_axi_lite_cfg_master;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [3:0]    cmd_strb;
  logic          rsp_valid, rsp_ready, rsp_write, busy;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_resp;
`ifdef AXI_MASTER_TIMEOUT_EN
  logic          timeout_err;
`endif

  always #5 clk = ~clk;

  axi_lite_cfg_master_if #(.DW(DW), .AW(AW)) axi ();

  axi_lite_cfg_master #(
    .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .busy(busy),
`ifdef AXI_MASTER_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .m_axi(axi)
  );

  // slave knobs
  int         k_aw = 0, k_w = 0, k_ar = 0, k_b = 0, k_r = 0;
  logic [1:0] k_bresp = 2'b00, k_rresp = 2'b00;
  logic [31:0] k_rdata = 32'h0;
  logic       k_never_r = 1'b0;

  logic s_aw_got, s_w_got, s_ar_got;
  int   s_awc, s_wc, s_arc, s_bc, s_rc;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign axi.M_AXI_AWREADY = axi.M_AXI_AWVALID && (s_awc >= k_aw);
  assign axi.M_AXI_WREADY  = axi.M_AXI_WVALID  && (s_wc  >= k_w);
  assign axi.M_AXI_ARREADY = axi.M_AXI_ARVALID && (s_arc >= k_ar);
  assign aw_hs = axi.M_AXI_AWVALID && axi.M_AXI_AWREADY;
  assign w_hs  = axi.M_AXI_WVALID  && axi.M_AXI_WREADY;
  assign ar_hs = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
  assign b_hs  = axi.M_AXI_BVALID  && axi.M_AXI_BREADY;
  assign r_hs  = axi.M_AXI_RVALID  && axi.M_AXI_RREADY;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_aw_got <= 1'b0; s_w_got <= 1'b0; s_ar_got <= 1'b0;
      s_awc <= 0; s_wc <= 0; s_arc <= 0; s_bc <= 0; s_rc <= 0;
      axi.M_AXI_BVALID <= 1'b0; axi.M_AXI_BRESP <= 2'b00;
      axi.M_AXI_RVALID <= 1'b0; axi.M_AXI_RRESP <= 2'b00; axi.M_AXI_RDATA <= '0;
    end else begin
      s_awc <= aw_hs ? 0 : (axi.M_AXI_AWVALID ? s_awc + 1 : 0);
      s_wc  <= w_hs  ? 0 : (axi.M_AXI_WVALID  ? s_wc  + 1 : 0);
      s_arc <= ar_hs ? 0 : (axi.M_AXI_ARVALID ? s_arc + 1 : 0);
      if (axi.M_AXI_BVALID) begin
        if (b_hs) axi.M_AXI_BVALID <= 1'b0;
      end else if ((s_aw_got || aw_hs) && (s_w_got || w_hs)) begin
        if (s_bc >= k_b) begin
          axi.M_AXI_BVALID <= 1'b1; axi.M_AXI_BRESP <= k_bresp;
          s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bc <= 0;
        end else begin
          s_bc <= s_bc + 1; s_aw_got <= 1'b1; s_w_got <= 1'b1;
        end
      end else begin
        if (aw_hs) s_aw_got <= 1'b1;
        if (w_hs)  s_w_got  <= 1'b1;
      end
      if (axi.M_AXI_RVALID) begin
        if (r_hs) axi.M_AXI_RVALID <= 1'b0;
      end else if ((s_ar_got || ar_hs) && !k_never_r) begin
        if (s_rc >= k_r) begin
          axi.M_AXI_RVALID <= 1'b1; axi.M_AXI_RDATA <= k_rdata; axi.M_AXI_RRESP <= k_rresp;
          s_ar_got <= 1'b0; s_rc <= 0;
        end else begin
          s_rc <= s_rc + 1; s_ar_got <= 1'b1;
        end
      end else if (ar_hs) s_ar_got <= 1'b1;
    end
  end

  // protocol monitor: B handshakes and any VALID withdrawn before READY
  int   n_b = 0, v_drop = 0;
  logic p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
  always @(posedge clk) begin
    if (!rst) begin
      if (b_hs) n_b <= n_b + 1;
      if ((p_aw && !axi.M_AXI_AWVALID) || (p_w && !axi.M_AXI_WVALID) ||
          (p_ar && !axi.M_AXI_ARVALID)) v_drop <= v_drop + 1;
      p_aw <= axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY;
      p_w  <= axi.M_AXI_WVALID  && !axi.M_AXI_WREADY;
      p_ar <= axi.M_AXI_ARVALID && !axi.M_AXI_ARREADY;
    end else begin
      p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  logic tr_awv[64], tr_awr[64], tr_wv[64], tr_wr[64], tr_br[64], tr_rr[64];
  int   addr_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic do_txn(input logic wr, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er,
                        input int hold, output int lat);
    exp_t e;
    logic [31:0] hd;
    logic [1:0]  hr;
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d; cmd_strb = s;
    e.wr = wr; e.data = ed; e.resp = er;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = ~a; cmd_data = ~d; cmd_strb = ~s;
    lat = 1; addr_bad = 0;
    forever begin
      tr_awv[lat] = axi.M_AXI_AWVALID; tr_awr[lat] = axi.M_AXI_AWREADY;
      tr_wv[lat]  = axi.M_AXI_WVALID;  tr_wr[lat]  = axi.M_AXI_WREADY;
      tr_br[lat]  = axi.M_AXI_BREADY;  tr_rr[lat]  = axi.M_AXI_RREADY;
      if ((axi.M_AXI_AWVALID && axi.M_AXI_AWADDR !== a) ||
          (axi.M_AXI_WVALID && (axi.M_AXI_WDATA !== d || axi.M_AXI_WSTRB !== s)) ||
          (axi.M_AXI_ARVALID && axi.M_AXI_ARADDR !== a)) addr_bad++;
      if (rsp_valid === 1'b1 || lat >= 60) break;
      @(negedge clk); lat++;
    end
    chk("rsp_valid_seen", rsp_valid, 1'b1);
    chk("addr_data_held", addr_bad, 0);
    e = sb.pop_front();
    chk("rsp_write", rsp_write, e.wr);
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_resp", rsp_resp, e.resp);
    hd = rsp_data; hr = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_stable", {rsp_data, rsp_resp}, {hd, hr});
      chk("hold_cmd_ready", cmd_ready, 1'b0);
      chk("hold_no_axi", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID,
                          axi.M_AXI_BREADY, axi.M_AXI_RREADY}, 5'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_consumed", rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb0;
    logic [31:0] rd;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_data = '0; cmd_strb = '0; rsp_ready = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_axi_vr", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID,
                       axi.M_AXI_BREADY, axi.M_AXI_RREADY}, 5'b0);
    chk("rst_regs", {axi.M_AXI_AWADDR, axi.M_AXI_WDATA, axi.M_AXI_WSTRB, rsp_data, rsp_resp}, '0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1'b1);
`ifdef AXI_MASTER_TIMEOUT_EN
    chk("to_err_reset", timeout_err, 1'b0);
`endif

    // zero-wait write
    nb0 = n_b;
    do_txn(1'b1, 16'h0000, 32'h0000_0011, 4'hF, 32'h0, 2'b00, 0, lat);
    chk("wr0_latency", lat, 3);
    chk("wr0_aw_w_same", {tr_awv[1], tr_awr[1], tr_wv[1], tr_wr[1]}, 4'hF);
    chk("wr0_bready", tr_br[2], 1'b1);
    chk("wr0_b_count", n_b - nb0, 1);
    chk("wr0_cmd_ready_back", cmd_ready, 1'b1);

    // AWREADY two cycles ahead of WREADY
    k_w = 2; nb0 = n_b;
    do_txn(1'b1, 16'h0008, 32'hCAFE_0001, 4'h3, 32'h0, 2'b00, 0, lat);
    chk("wr1_latency", lat, 5);
    chk("wr1_aw_first", {tr_awv[1], tr_awr[1], tr_awv[2], tr_awv[3]}, 4'b1100);
    chk("wr1_w_held", {tr_wv[1], tr_wv[2], tr_wv[3], tr_wr[1], tr_wr[2], tr_wr[3]}, 6'b111001);
    chk("wr1_b_count", n_b - nb0, 1);
    k_w = 0;

    // read with RVALID delayed, SLVERR passed through
    k_r = 5; k_rdata = 32'hDEAD_BEEF; k_rresp = 2'b10;
    do_txn(1'b0, 16'h0004, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF, 2'b10, 0, lat);
    chk("rd0_latency", lat, 8);
    rd = '0;
    for (int i = 1; i <= 7; i++) rd[i] = tr_rr[i];
    chk("rd0_rready_thru", rd, 32'h0000_00FC);
    k_r = 0;

    // response back-pressure for 4 cycles, write SLVERR
    k_bresp = 2'b10;
    do_txn(1'b1, 16'h0101, 32'hA5A5_5A5A, 4'h9, 32'h0, 2'b10, 4, lat);
    chk("bp_latency", lat, 3);
    chk("bp_cmd_ready_back", cmd_ready, 1'b1);
    k_bresp = 2'b00;

    // zero-wait read right after
    k_rdata = 32'h0BAD_F00D; k_rresp = 2'b00;
    do_txn(1'b0, 16'h0020, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 0, lat);
    chk("rd1_latency", lat, 3);

    // async reset while waiting in WR_B
    k_b = 10;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h000C; cmd_data = 32'h55; cmd_strb = 4'hF;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("wrb_bready", {axi.M_AXI_BREADY, busy}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_axi_vr", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID,
                        axi.M_AXI_BREADY, axi.M_AXI_RREADY, rsp_valid}, 6'b0);
    chk("arst_regs", {axi.M_AXI_AWADDR, axi.M_AXI_WDATA, axi.M_AXI_WSTRB, rsp_data, rsp_resp}, '0);
    @(negedge clk); rst = 1'b0; k_b = 0;
    do_txn(1'b1, 16'h000C, 32'h0000_0055, 4'hF, 32'h0, 2'b00, 0, lat);
    chk("post_rst_latency", lat, 3);

`ifdef AXI_MASTER_TIMEOUT_EN
    // read whose slave never answers
    k_never_r = 1'b1;
    do_txn(1'b0, 16'h0010, 32'h0, 4'h0, 32'h0, 2'b11, 0, lat);
    chk("to_latency", lat, TO + 3);
    chk("to_err_set", timeout_err, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("to_blocked", {cmd_ready, busy}, 2'b00);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rst = 1'b1; k_never_r = 1'b0;
    @(negedge clk);
    chk("to_err_cleared", timeout_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    k_rdata = 32'h600D_0001;
    do_txn(1'b0, 16'h0010, 32'h0, 4'h0, 32'h600D_0001, 2'b00, 0, lat);
    chk("to_recover_latency", lat, 3);
`endif

    chk("no_valid_withdrawn", v_drop, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_cfg_master.md
Name: axi_lite_cfg_master

Overview:
- Single-outstanding AXI4-Lite initiator. It turns simple command/response handshakes into AXI4-Lite write and read transactions.
- It drives the S_AXI port of the DFR core register block: ctrl, mem_addr/mem_data and the sample-count registers. It is used by the on-chip loader/sequencer and by the bench as the bus master.
- One transaction is in flight at a time. Write address and write data are issued concurrently.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width. Must be 32 or 64.
- C_M_AXI_ADDR_WIDTH, 16, AXI address width.
- TIMEOUT_CYCLES, 1024, response-wait limit. Used only with AXI_MASTER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid is also high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
- cmd_data  in  C_M_AXI_DATA_WIDTH  write data. Ignored for reads.
- cmd_strb  in  C_M_AXI_DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  copy of cmd_write for this response.
- rsp_data  out  C_M_AXI_DATA_WIDTH  read data. 0 for writes.
- rsp_resp  out  2  BRESP or RRESP, or 2'b11 on timeout.
- busy  out  1  high whenever the state is not IDLE.
- M_AXI_AWADDR/AWVALID out, M_AXI_AWREADY in: write address channel.
- M_AXI_WDATA/WSTRB/WVALID out, M_AXI_WREADY in: write data channel.
- M_AXI_BRESP/BVALID in, M_AXI_BREADY out: write response channel.
- M_AXI_ARADDR/ARVALID out, M_AXI_ARREADY in: read address channel.
- M_AXI_RDATA/RRESP/RVALID in, M_AXI_RREADY out: read data channel.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE.
  - All VALID/READY outputs = 0, rsp_valid=0, busy=0.
  - All address, data, strobe and resp registers = 0.
  - Reset mid-transaction drops the transaction with no response. The bench resets the slave together with the master.
- States: IDLE, WR, WR_B, RD_A, RD_R, RESP.
- IDLE:
  - cmd_ready=1 (combinational from state).
  - On cmd_valid&cmd_ready: latch addr/data/strb/write. Next state is WR if cmd_write=1, else RD_A.
- WR:
  - AWVALID=WVALID=1 from the first cycle in the state. Both are registered outputs.
  - aw_done and w_done flags track each handshake independently. A VALID drops the cycle after its own handshake.
  - Both handshakes in the same cycle are legal.
  - When both flags are set (the last handshake cycle), next state is WR_B. The flags clear on entry to WR_B.
  - VALID is never withdrawn before READY.
- WR_B:
  - BREADY=1.
  - On BVALID: latch BRESP into rsp_resp, set rsp_data=0, next state RESP.
- RD_A:
  - ARVALID=1.
  - On ARREADY: next state RD_R.
- RD_R:
  - RREADY=1.
  - On RVALID: latch RDATA into rsp_data and RRESP into rsp_resp, next state RESP.
- RESP:
  - rsp_valid=1. rsp_* stay stable until rsp_ready.
  - On rsp_ready: next state IDLE. cmd_ready returns the following cycle, so back-to-back commands are separated by at least one idle cycle.
- Minimum latency with a zero-wait slave:
  - Write: accept → AW/W cycle → B cycle → rsp_valid on the 3rd cycle after acceptance.
  - Read: the same, 3 cycles.
- AWADDR/ARADDR/WDATA/WSTRB are held constant for the whole transaction. Addresses are passed through unaligned; alignment is the caller's job.
- Responses pass through unmodified, including SLVERR (2'b10).

Optional Feature:
- Macro: AXI_MASTER_TIMEOUT_EN.
- When defined:
  - A cycle counter (width clog2(TIMEOUT_CYCLES)+1) runs in WR_B and RD_R and clears on state entry.
  - If it reaches TIMEOUT_CYCLES with no BVALID/RVALID: BREADY/RREADY=0, rsp_resp=2'b11, rsp_data=0, next state RESP.
  - Output timeout_err (1 bit, sticky) is set. It clears only on rst.
  - While timeout_err=1, cmd_ready=0, so the master blocks until reset.
  - AW/W/AR valid phases are never timed out, to keep AXI rules intact.
- When undefined: no counter and no timeout_err port. The master waits forever.

Test Plan:
- Zero-wait write, addr 0x0000, data 0x0000_0011, strb 0xF → AW and W in the same cycle, rsp_valid 3 cycles after acceptance, rsp_resp=00, rsp_write=1, rsp_data=0.
- Slave asserts AWREADY 2 cycles before WREADY → AWVALID drops after its handshake, WVALID holds until WREADY, then exactly one BREADY handshake.
- Read addr 0x0004 with RVALID delayed 5 cycles, RDATA 0xDEADBEEF, RRESP=10 → rsp_data=0xDEADBEEF, rsp_resp=10, RREADY high throughout.
- rsp_ready held low for 4 cycles → rsp_* stable, cmd_ready=0, no new AXI activity; cmd_ready=1 the cycle after rsp_ready.
- rst pulsed while in WR_B → all outputs 0 immediately (asynchronous), state IDLE; the next write completes normally.
- With AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, a read whose slave never asserts RVALID → rsp_resp=11 after 16 cycles in RD_R, timeout_err=1, cmd_ready stays 0 until rst.
